// File: rtl/mesh_local_sink.sv
// rtl/mesh_local_sink.sv - ejection-side flit sink with FWFT FIFO, registered hold and statistics
//
// Purpose:
//   Consumes flits emitted by one mesh router output port, buffers them in a
//   small first-word-fall-through FIFO, backpressures the router through a
//   registered hold line and hands flits to the local core over valid/ready.
//
// Ports:
//   clk, reset      - clock, synchronous active-high reset
//   dataIn          - flit from router output port
//   writeRequest    - dataIn valid this cycle
//   holdPort        - registered backpressure to the router
//   coreData        - FIFO head flit (0 when empty)
//   coreValid       - FIFO non-empty
//   coreReady       - core consumes head when coreValid & coreReady
//   rxCount         - saturating count of accepted flits
//   dropCount       - saturating count of dropped flits
//   overflowErr     - sticky: flit arrived while full with no pop
//   misrouteErr     - sticky: flit address differs from this node
//
// Optional feature: MESH_SINK_ADDR_CHECK_EN enables destination address
// checking; without it every valid flit is stored and misrouteErr is 0.

module mesh_local_sink #(
  parameter int X_LOC      = 1,
  parameter int Y_LOC      = 1,
  parameter int X_NODES    = 9,
  parameter int Y_NODES    = 9,
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int HOLD_SLACK = 2,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] dataIn,
  input  logic                  writeRequest,
  output logic                  holdPort,
  output logic [DATA_WIDTH-1:0] coreData,
  output logic                  coreValid,
  input  logic                  coreReady,
  output logic [CNT_WIDTH-1:0]  rxCount,
  output logic [CNT_WIDTH-1:0]  dropCount,
  output logic                  overflowErr,
  output logic                  misrouteErr
);

  localparam int XB   = $clog2(X_NODES);
  localparam int YB   = $clog2(Y_NODES);
  localparam int PTRW = $clog2(FIFO_DEPTH);
  localparam int CW   = PTRW + 1;

  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] HOLD_TH  = CW'(FIFO_DEPTH - HOLD_SLACK);

  // Reject configurations the FIFO/hold arithmetic cannot support.
  if (X_LOC < 0 || X_LOC >= X_NODES || Y_LOC < 0 || Y_LOC >= Y_NODES ||
      FIFO_DEPTH < 4 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 ||
      HOLD_SLACK < 2 || HOLD_SLACK > FIFO_DEPTH - 1) begin : g_bad_params
    $error("mesh_local_sink: illegal parameter combination");
  end

  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [FIFO_DEPTH];
  logic [PTRW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [PTRW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  hold_q, hold_d;
  logic [CNT_WIDTH-1:0]  rx_cnt_q, rx_cnt_d;
  logic [CNT_WIDTH-1:0]  drop_cnt_q, drop_cnt_d;
  logic                  ovf_q, ovf_d;

  logic present;
  logic misroute;
  logic full;
  logic empty;
  logic pop;
  logic push;
  logic overflow;
  logic drop;

  // A flit is only real when both the strobe and its own valid bit are set.
  assign present = writeRequest & dataIn[DATA_WIDTH-1];

`ifdef MESH_SINK_ADDR_CHECK_EN
  logic mis_q, mis_d;

  assign misroute = present &
                    ((dataIn[DATA_WIDTH-2 -: XB] != XB'(X_LOC)) |
                     (dataIn[DATA_WIDTH-2-XB -: YB] != YB'(Y_LOC)));

  always_comb begin
    mis_d = mis_q | misroute;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mis_q <= 1'b0;
    end else begin
      mis_q <= mis_d;
    end
  end

  assign misrouteErr = mis_q;
`else
  assign misroute    = 1'b0;
  assign misrouteErr = 1'b0;
`endif

  assign full     = (count_q == FULL_CNT);
  assign empty    = (count_q == '0);
  assign pop      = ~empty & coreReady;
  // When full, a same-edge pop frees the slot the push lands in.
  assign push     = present & ~misroute & (~full | pop);
  assign overflow = present & full & ~pop;
  // A flit that is both misrouted and overflowing is counted once.
  assign drop     = present & (misroute | overflow);

  always_comb begin
    mem_d = mem_q;
    if (push) begin
      mem_d[wr_ptr_q] = dataIn;
    end

    wr_ptr_d = push ? wr_ptr_q + PTRW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTRW'(1) : rd_ptr_q;

    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    // Hold follows the occupancy that will exist after this edge, so the
    // router sees it one cycle later and still has HOLD_SLACK-1 slots left.
    hold_d = (count_d >= HOLD_TH);

    rx_cnt_d = rx_cnt_q;
    if (push && (rx_cnt_q != '1)) begin
      rx_cnt_d = rx_cnt_q + CNT_WIDTH'(1);
    end

    drop_cnt_d = drop_cnt_q;
    if (drop && (drop_cnt_q != '1)) begin
      drop_cnt_d = drop_cnt_q + CNT_WIDTH'(1);
    end

    ovf_d = ovf_q | overflow;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_q      <= '{default: '0};
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      hold_q     <= 1'b0;
      rx_cnt_q   <= '0;
      drop_cnt_q <= '0;
      ovf_q      <= 1'b0;
    end else begin
      mem_q      <= mem_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      hold_q     <= hold_d;
      rx_cnt_q   <= rx_cnt_d;
      drop_cnt_q <= drop_cnt_d;
      ovf_q      <= ovf_d;
    end
  end

  assign holdPort    = hold_q;
  assign coreValid   = ~empty;
  assign coreData    = empty ? '0 : mem_q[rd_ptr_q];
  assign rxCount     = rx_cnt_q;
  assign dropCount   = drop_cnt_q;
  assign overflowErr = ovf_q;

endmodule

// File: tb/tb_mesh_local_sink.sv
// tb/tb_mesh_local_sink.sv - self-checking bench for mesh_local_sink

module tb_mesh_local_sink;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] dataIn;
  logic        writeRequest;
  logic        holdPort;
  logic [31:0] coreData;
  logic        coreValid;
  logic        coreReady;
  logic [15:0] rxCount;
  logic [15:0] dropCount;
  logic        overflowErr;
  logic        misrouteErr;

  always #5 clk = ~clk;

  mesh_local_sink dut (
    .clk         (clk),
    .reset       (reset),
    .dataIn      (dataIn),
    .writeRequest(writeRequest),
    .holdPort    (holdPort),
    .coreData    (coreData),
    .coreValid   (coreValid),
    .coreReady   (coreReady),
    .rxCount     (rxCount),
    .dropCount   (dropCount),
    .overflowErr (overflowErr),
    .misrouteErr (misrouteErr)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: a plain queue of stored flits plus counters and flags.
  logic [31:0] mq[$];
  int unsigned m_rx, m_drop;
  bit          m_ovf, m_mis;

`ifdef MESH_SINK_ADDR_CHECK_EN
  localparam bit ADDR_CHK = 1'b1;
`else
  localparam bit ADDR_CHK = 1'b0;
`endif

  typedef struct {
    bit          wr;
    logic [31:0] din;
    bit          rdy;
    logic [31:0] data;
    bit          valid;
    bit          hold;
    int          rx;
    int          drop;
  } vec_t;

  vec_t tbl[17];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_step(input bit rst, input bit wr, input logic [31:0] din, input bit rdy);
    bit present, mis, full, pop, accept;
    if (rst) begin
      mq.delete();
      m_rx = 0; m_drop = 0; m_ovf = 0; m_mis = 0;
      return;
    end
    present = wr && din[31];
    mis     = ADDR_CHK && present && ((din[30:27] != 4'd1) || (din[26:23] != 4'd1));
    full    = (mq.size() == 4);
    pop     = (mq.size() > 0) && rdy;
    accept  = 0;
    if (present) begin
      if (mis || (full && !pop)) begin
        if (m_drop < 65535) m_drop++;
        if (full && !pop) m_ovf = 1;
        if (mis) m_mis = 1;
      end else begin
        accept = 1;
      end
    end
    if (pop) void'(mq.pop_front());
    if (accept) begin
      mq.push_back(din);
      if (m_rx < 65535) m_rx++;
    end
  endtask

  task automatic compare_model(input string tag);
    chk({tag, ".valid"}, {31'b0, coreValid}, {31'b0, mq.size() > 0});
    chk({tag, ".data"},  coreData, (mq.size() > 0) ? mq[0] : 32'h0);
    chk({tag, ".hold"},  {31'b0, holdPort}, {31'b0, mq.size() >= 2});
    chk({tag, ".rx"},    {16'b0, rxCount}, m_rx);
    chk({tag, ".drop"},  {16'b0, dropCount}, m_drop);
    chk({tag, ".ovf"},   {31'b0, overflowErr}, {31'b0, m_ovf});
    chk({tag, ".mis"},   {31'b0, misrouteErr}, {31'b0, m_mis});
  endtask

  task automatic cycle(input bit rst, input bit wr, input logic [31:0] din, input bit rdy, input string tag);
    reset        = rst;
    writeRequest = wr;
    dataIn       = din;
    coreReady    = rdy;
    model_step(rst, wr, din, rdy);
    @(posedge clk);
    #1;
    compare_model(tag);
  endtask

  initial begin
    reset = 1'b1; writeRequest = 1'b0; dataIn = '0; coreReady = 1'b0;

    // Directed table: inputs and hand-derived outputs after the edge.
    tbl[0]  = '{1, 32'h888000AA, 1, 32'h888000AA, 1, 0, 1, 0};
    tbl[1]  = '{1, 32'h888000BB, 1, 32'h888000BB, 1, 0, 2, 0};
    tbl[2]  = '{1, 32'h888000CC, 1, 32'h888000CC, 1, 0, 3, 0};
    tbl[3]  = '{0, 32'h0,        1, 32'h0,        0, 0, 3, 0};
    tbl[4]  = '{1, 32'h088000FF, 0, 32'h0,        0, 0, 3, 0};
    tbl[5]  = '{1, 32'h88800001, 0, 32'h88800001, 1, 0, 4, 0};
    tbl[6]  = '{1, 32'h88800002, 0, 32'h88800001, 1, 1, 5, 0};
    tbl[7]  = '{1, 32'h88800003, 0, 32'h88800001, 1, 1, 6, 0};
    tbl[8]  = '{1, 32'h88800004, 0, 32'h88800001, 1, 1, 7, 0};
    tbl[9]  = '{1, 32'h888000EE, 0, 32'h88800001, 1, 1, 7, 1};
    tbl[10] = '{1, 32'h888000EE, 1, 32'h88800002, 1, 1, 8, 1};
    tbl[11] = '{0, 32'h0,        1, 32'h88800003, 1, 1, 8, 1};
    tbl[12] = '{0, 32'h0,        1, 32'h88800004, 1, 1, 8, 1};
    tbl[13] = '{0, 32'h0,        1, 32'h888000EE, 1, 0, 8, 1};
    tbl[14] = '{0, 32'h0,        1, 32'h0,        0, 0, 8, 1};
`ifdef MESH_SINK_ADDR_CHECK_EN
    tbl[15] = '{1, 32'h89000011, 0, 32'h0,        0, 0, 8, 2};
    tbl[16] = '{0, 32'h0,        1, 32'h0,        0, 0, 8, 2};
`else
    tbl[15] = '{1, 32'h89000011, 0, 32'h89000011, 1, 0, 9, 1};
    tbl[16] = '{0, 32'h0,        1, 32'h0,        0, 0, 9, 1};
`endif

    cycle(1, 0, '0, 0, "rst0");
    cycle(1, 1, 32'h888000AA, 1, "rst1");
    chk("reset.hold",  {31'b0, holdPort}, 32'h0);
    chk("reset.valid", {31'b0, coreValid}, 32'h0);
    chk("reset.data",  coreData, 32'h0);
    chk("reset.rx",    {16'b0, rxCount}, 32'h0);
    chk("reset.drop",  {16'b0, dropCount}, 32'h0);
    chk("reset.ovf",   {31'b0, overflowErr}, 32'h0);
    chk("reset.mis",   {31'b0, misrouteErr}, 32'h0);

    for (int i = 0; i < 17; i++) begin
      cycle(0, tbl[i].wr, tbl[i].din, tbl[i].rdy, $sformatf("tbl%0d", i));
      chk($sformatf("tbl%0d.data", i),  coreData, tbl[i].data);
      chk($sformatf("tbl%0d.valid", i), {31'b0, coreValid}, {31'b0, tbl[i].valid});
      chk($sformatf("tbl%0d.hold", i),  {31'b0, holdPort}, {31'b0, tbl[i].hold});
      chk($sformatf("tbl%0d.rx", i),    {16'b0, rxCount}, tbl[i].rx);
      chk($sformatf("tbl%0d.drop", i),  {16'b0, dropCount}, tbl[i].drop);
    end
    chk("tbl.ovf_sticky", {31'b0, overflowErr}, 32'h1);
    chk("tbl.mis_flag",   {31'b0, misrouteErr}, {31'b0, ADDR_CHK});

    // Router honouring a registered hold: it acts on the hold value from one
    // cycle before the one currently visible.
    begin
      int          sent = 0;
      int          cyc = 0;
      int          drop_before;
      bit          hold_prev = 0, hold_seen = 0, wr;
      drop_before = dropCount;
      while ((sent < 8 || mq.size() > 0) && cyc < 100) begin
        wr = (sent < 8) && !hold_seen;
        hold_seen = hold_prev;
        cycle(0, wr, 32'h88800001 + sent, cyc >= 10, $sformatf("flow%0d", cyc));
        if (wr) sent++;
        hold_prev = holdPort;
        cyc++;
      end
      chk("flow.done_in_budget", {31'b0, cyc < 100}, 32'h1);
      chk("flow.no_drop", {16'b0, dropCount}, drop_before);
      chk("flow.hold_released", {31'b0, holdPort}, 32'h0);
    end

    // Mid-stream reset with 3 flits queued.
    for (int i = 0; i < 3; i++) cycle(0, 1, 32'h88800030 + i, 0, "mid_fill");
    chk("mid.queued", {31'b0, coreValid}, 32'h1);
    cycle(1, 1, 32'h88800099, 1, "mid_rst");
    chk("mid.valid", {31'b0, coreValid}, 32'h0);
    chk("mid.hold",  {31'b0, holdPort}, 32'h0);
    chk("mid.rx",    {16'b0, rxCount}, 32'h0);
    chk("mid.drop",  {16'b0, dropCount}, 32'h0);
    chk("mid.ovf",   {31'b0, overflowErr}, 32'h0);

    // Eight-flit pass to walk the pointers around the ring twice.
    for (int i = 0; i < 8; i++) cycle(0, 1, 32'h88800040 + i, i >= 2, "wrap");
    for (int i = 0; i < 4; i++) cycle(0, 0, '0, 1, "wrap_drain");
    chk("wrap.rx", {16'b0, rxCount}, 32'd8);

    // Randomised traffic, ignoring hold so overflow paths get exercised.
    for (int i = 0; i < 400; i++) begin
      logic [31:0] d;
      d = $urandom;
      d[31] = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 3) != 0) d[30:23] = 8'b0001_0001;
      cycle($urandom_range(0, 99) == 0, $urandom_range(0, 2) != 0, d,
            $urandom_range(0, 1) == 1, $sformatf("rnd%0d", i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
